// File: rtl/mul4_shift_add_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier: widths, the state
// encoding and a small helper used by the control FSM.
package mul4_shift_add_pkg;

    localparam int MUL_W  = 4;
    localparam int PROD_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A new operation may be accepted from IDLE, or back-to-back from DONE.
    function automatic logic can_accept(input state_t s);
        return (s == S_IDLE) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/mul4_shift_add_add_4.sv
// Existing 4-bit ripple-carry adder reused by the multiplier datapath.
module add_4 (
    input  logic [3:0] add_0,
    input  logic [3:0] add_1,
    input  logic       c_in,
    output logic [3:0] out,
    output logic       c_out
);

    logic [4:0] w_carry;

    assign w_carry[0] = c_in;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_fa
            assign out[g]         = add_0[g] ^ add_1[g] ^ w_carry[g];
            assign w_carry[g + 1] = (add_0[g] & add_1[g])
                                  | (add_0[g] & w_carry[g])
                                  | (add_1[g] & w_carry[g]);
        end
    endgenerate

    assign c_out = w_carry[4];

endmodule

// File: rtl/mul4_shift_add.sv
// Sequential 4x4 unsigned shift-and-add multiplier built on add_4.
// Handshake: start is sampled only in IDLE/DONE; busy is high in RUN; done pulses one cycle with product valid.
module mul4_shift_add
    import mul4_shift_add_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ITER  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [PROD_W-1:0]  product
);

    state_t              r_state;
    state_t              w_next_state;

    logic [MUL_W-1:0]    r_m;
    logic [MUL_W-1:0]    r_a;
    logic [MUL_W-1:0]    r_q;
    logic                r_c;
    logic [CNT_W-1:0]    r_cnt;
    logic [PROD_W-1:0]   r_product;

    logic [MUL_W-1:0]    w_sum;
    logic                w_cout;
    logic [MUL_W-1:0]    w_a_post;
    logic                w_c_post;
    logic [MUL_W-1:0]    w_a_next;
    logic [MUL_W-1:0]    w_q_next;
    logic                w_accept;
    logic                w_last;

    add_4 u_add_4 (
        .add_0 (r_a),
        .add_1 (r_m),
        .c_in  (1'b0),
        .out   (w_sum),
        .c_out (w_cout)
    );

    // r_c is always zero entering a RUN edge, so the no-add branch keeps {0,A}.
    assign w_a_post = r_q[0] ? w_sum  : r_a;
    assign w_c_post = r_q[0] ? w_cout : r_c;
    assign w_a_next = {w_c_post, w_a_post[MUL_W-1:1]};
    assign w_q_next = {w_a_post[0], r_q[MUL_W-1:1]};

    assign w_accept = start && can_accept(r_state);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_m   <= a;
            r_q   <= b;
            r_a   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_c   <= 1'b0;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= {w_a_next, w_q_next};
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mul4_shift_add.sv
// Self-checking bench for mul4_shift_add: directed handshake scenarios plus
// random operand pairs compared against plain a*b arithmetic.
module tb_mul4_shift_add;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int vectors;
    int miscompares;
    logic [7:0] last_prod;

    mul4_shift_add #(.WIDTH(4), .ITER(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic exp_busy, input logic exp_done,
                           input logic [7:0] exp_prod);
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, exp_busy});
        chk({tag, "_done"}, {7'd0, done}, {7'd0, exp_done});
        chk({tag, "_prod"}, product, exp_prod);
    endtask

    // One full operation: start accepted at the next edge, four RUN cycles,
    // one DONE cycle, then one idle cycle confirming a single done pulse.
    task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input bit jitter, input bit repulse);
        logic [7:0] exp_prod;
        exp_prod = 8'(x) * 8'(y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_ctl({tag, "_run"}, 1'b1, 1'b0, last_prod);
            start = 1'b0;
            if (repulse && i == 1) begin
                start = 1'b1; a = 4'd1; b = 4'd1;
            end
            if (jitter) begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk_ctl({tag, "_done"}, 1'b0, 1'b1, exp_prod);
        last_prod = exp_prod;
        @(negedge clk);
        chk_ctl({tag, "_after"}, 1'b0, 1'b0, last_prod);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_prod   = 8'h00;
        rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (3) @(negedge clk);
        chk_ctl("reset", 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_ctl("idle_hold", 1'b0, 1'b0, 8'h00);
        end

        run_op("f_x_f", 4'd15, 4'd15, 1'b0, 1'b0);
        run_op("3_x_5", 4'd3, 4'd5, 1'b0, 1'b0);
        run_op("9_x_0", 4'd9, 4'd0, 1'b0, 1'b0);
        run_op("6_x_7_jit", 4'd6, 4'd7, 1'b1, 1'b1);

        // Reset asserted in the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 4'd12; b = 4'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk_ctl("abort_run1", 1'b1, 1'b0, last_prod);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_ctl("abort_rst", 1'b0, 1'b0, 8'h00);
        last_prod = 8'h00;
        @(negedge clk);
        chk_ctl("abort_hold", 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ctl("abort_idle", 1'b0, 1'b0, 8'h00);
        run_op("12_x_10", 4'd12, 4'd10, 1'b0, 1'b0);

        // Back-to-back with start held high: second op accepted from DONE.
        @(negedge clk);
        a = 4'd2; b = 4'd3; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_ctl("b2b1_run", 1'b1, 1'b0, last_prod);
        end
        @(negedge clk);
        chk_ctl("b2b1_done", 1'b0, 1'b1, 8'h06);
        last_prod = 8'h06;
        a = 4'd4; b = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_ctl("b2b2_run", 1'b1, 1'b0, last_prod);
        end
        @(negedge clk);
        chk_ctl("b2b2_done", 1'b0, 1'b1, 8'h10);
        last_prod = 8'h10;
        start = 1'b0;
        @(negedge clk);
        chk_ctl("b2b_after", 1'b0, 1'b0, last_prod);

        for (int n = 0; n < 100; n++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'b1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul4_shift_add.md
Name: mul4_shift_add

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier.
- Sits directly downstream of the 4-bit ripple adder `add_4` and is its consumer: it drives the adder's operands and registers the adder's sum and carry every cycle.
- Produces an 8-bit product after a fixed 4-iteration run, using a start/busy/done handshake.
- Used by the lab top level as the first multi-cycle arithmetic block built on the existing adder.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported, because the datapath instantiates the fixed 4-bit `add_4`.
- ITER, 4, number of add/shift iterations. Must equal WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to multiply; sampled only in IDLE or DONE.
- a  input  4  multiplicand, unsigned; captured when start is accepted.
- b  input  4  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  8  registered result a*b; holds until the next accepted start completes.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=8'h00; internal regs M, A, Q, C and cnt all cleared. Reset asserted mid-RUN aborts the operation with no done pulse; product reads 0.
- Internal registers: M[3:0] multiplicand, A[3:0] accumulator, Q[3:0] multiplier/low product, C carry bit, cnt[2:0] iteration counter.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: M<=a, Q<=b, A<=0, C<=0, cnt<=0, go to RUN.
- RUN:
  - busy=1.
  - Adder connection: `add_0`=A, `add_1`=M, `c_in`=0.
  - Each edge, if Q[0]=1, {C,A} takes {`c_out`,`out`}; else {C,A} takes {0,A}.
  - In the same edge, {C,A,Q} is shifted right by 1 using the post-add value: A<={C',A'[3:1]}, Q<={A'[0],Q[3:1]}, C<=0.
  - cnt<=cnt+1. On the edge where cnt==ITER-1, product<={A_next,Q_next} and go to DONE.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - The next edge returns to IDLE. If start=1 on that edge, the operation is accepted exactly as from IDLE (back-to-back), and the next state is RUN.
- Latency: start accepted at edge k; RUN covers edges k+1..k+4; done is high in the cycle after edge k+4. Throughput is one result per 5 cycles back-to-back.
- start while busy=1 is ignored; there is no queueing and no error flag.
- a and b are don't-care except on the accepting edge; changes during RUN must not affect the result.
- Arithmetic: unsigned only. The carry from `add_4` is never lost, because it is shifted into A[3]. 15*15=225 fits in 8 bits; overflow is impossible.
- product changes only on the RUN to DONE transition or on reset; it is stable through IDLE and RUN of the next operation.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Decomposition:
- Shared package holds:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - MUL_W=4 and PROD_W=8.
- One natural sub-module: the existing `add_4`, instantiated once with ports `add_0`, `add_1`, `c_in`, `out` and `c_out`.
- Control FSM and shift registers stay in mul4_shift_add; no further split is needed.

Test Plan:
- Reset release, no start -> busy=0, done=0, product=0x00 held for 20 cycles.
- a=15, b=15, start pulse at edge k -> busy=1 during cycles k+1..k+4; done=1 only in the cycle after edge k+4; product=0xE1. Checks carry into A.
- a=3, b=5 -> product=0x0F. Then a=9, b=0 -> product=0x00 with done still pulsing.
- a=6, b=7 started; start re-pulsed with a=1, b=1 at RUN cycle 2, and a/b toggled during RUN -> product=0x2A, only one done pulse.
- rst_n pulled low at RUN cycle 2 of a=12, b=10 -> immediately busy=0, done=0, product=0x00. After release, a new start with a=12, b=10 -> product=0x78.
- Back-to-back: start held high continuously with a=2, b=3, then a=4, b=4 presented in the DONE cycle -> done pulses 5 cycles apart, products 0x06 then 0x10.
- Random 100 operand pairs against a reference a*b -> all match.
